// File: rtl/bin_bcd_conv.sv
// bin_bcd_conv -- sequential binary-to-BCD converter (shift-and-add-3),
// one input bit consumed every two clocks (ADJ then SHIFT).
//
// Ports:
//   clk    system clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   gen    start request, sampled only while idle
//   bin    binary value, captured on the accepting edge
//   busy   high while a conversion is in progress
//   done   one-cycle pulse when bcd/blank/ovf have been updated
//   bcd    result digits, digit i at [4i+3:4i], digit 0 least significant
//   blank  bit i set: digit i is a suppressed leading zero (bit 0 never set)
//   ovf    last converted value did not fit in DIGITS digits (bcd saturated)

// Per-digit add-3 correction applied before every shift.
module bin_bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin_bcd_conv #(
  parameter int BIN_W  = 17,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  gen,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  // Reset shows a single "0": every digit blanked except the units digit.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {IDLE, ADJ, SHIFT, FINISH} state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     work, work_adj, res;
  logic [BIN_W-1:0]  shreg;
  logic [CW-1:0]     cnt;
  logic              sticky;
  logic [DIGITS-1:0] blank_nxt;
  logic              allz;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bin_bcd_digit_adj u_adj (
        .din  (work[4*g +: 4]),
        .dout (work_adj[4*g +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gen) state_nxt = ADJ;
      ADJ:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (cnt == CW'(1)) ? FINISH : ADJ;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturate to all nines once any bit has fallen off the top digit.
  assign res = sticky ? {DIGITS{4'd9}} : work;

  // Walk from the top digit down; a digit is blank while everything above
  // and including it is zero. Units digit is always shown.
  always_comb begin
    blank_nxt = '0;
    allz      = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      allz         = allz & (res[4*i +: 4] == 4'd0);
      blank_nxt[i] = allz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      shreg  <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      bcd    <= '0;
      blank  <= BLANK_RST;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: if (gen) begin
          shreg  <= bin;
          work   <= '0;
          sticky <= 1'b0;
          cnt    <= CW'(BIN_W);
        end
        ADJ: work <= work_adj;
        SHIFT: begin
          work   <= {work[BW-2:0], shreg[BIN_W-1]};
          shreg  <= {shreg[BIN_W-2:0], 1'b0};
          sticky <= sticky | work[BW-1];
          cnt    <= cnt - CW'(1);
        end
        FINISH: begin
          bcd   <= res;
          blank <= blank_nxt;
          ovf   <= sticky;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
